// File: rtl/csa_accumulator.sv
// Packet accumulator holding its running total in carry-save form (one 3:2 step per beat),
// resolved to binary by a K-bit-per-cycle carry-propagate pass before being presented downstream.
module csa_accumulator #(
    parameter int n = 8,
    parameter int W = 12,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [n-1:0] in_data_i,
    input  logic         in_last_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [7:0]   out_count_o
);

    localparam int NCHUNK = W / K;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    s_q, s_d;
    logic [W-1:0]    c_q, c_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [7:0]      out_count_q, out_count_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]   chunk_q, chunk_d;
    logic            cin_q, cin_d;

    logic [W-1:0]    x_s;
    logic [W-1:0]    maj_s;
    logic [K-1:0]    s_chunk_s;
    logic [K-1:0]    c_chunk_s;
    logic [K:0]      chunk_sum_s;

    assign x_s   = W'(in_data_i);
    assign maj_s = (s_q & x_s) | (x_s & c_q) | (c_q & s_q);

    assign in_ready_o  = (state_q == ST_ACCUM);
    assign out_valid_o = (state_q == ST_OUTPUT);
    assign out_data_o  = out_data_q;
    assign out_count_o = out_count_q;

    // Pick the current K-bit slice of the redundant pair and add it with the carried-in bit.
    always_comb begin
        s_chunk_s = '0;
        c_chunk_s = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (chunk_q == CW'(i)) begin
                s_chunk_s = s_q[i*K +: K];
                c_chunk_s = c_q[i*K +: K];
            end else begin
                s_chunk_s = s_chunk_s;
                c_chunk_s = c_chunk_s;
            end
        end
        chunk_sum_s = {1'b0, s_chunk_s} + {1'b0, c_chunk_s} + {{K{1'b0}}, cin_q};
    end

    // Next-state and datapath update for the accumulate / resolve / output sequence.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        beat_cnt_d  = beat_cnt_q;
        chunk_d     = chunk_q;
        cin_d       = cin_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_valid_i) begin
                    s_d = s_q ^ x_s ^ c_q;
                    c_d = {maj_s[W-2:0], 1'b0};
                    if (beat_cnt_q != 8'hFF) begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end else begin
                        beat_cnt_d = beat_cnt_q;
                    end
                    if (in_last_i) begin
                        state_d = ST_RESOLVE;
                        chunk_d = '0;
                        cin_d   = 1'b0;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_RESOLVE: begin
                for (int i = 0; i < NCHUNK; i++) begin
                    if (chunk_q == CW'(i)) begin
                        out_data_d[i*K +: K] = chunk_sum_s[K-1:0];
                    end else begin
                        out_data_d[i*K +: K] = out_data_q[i*K +: K];
                    end
                end
                cin_d = chunk_sum_s[K];
                if (chunk_q == LAST_CHUNK) begin
                    // Final carry-out is dropped: the result wraps modulo 2^W.
                    state_d     = ST_OUTPUT;
                    out_count_d = beat_cnt_q;
                    chunk_d     = '0;
                end else begin
                    chunk_d = chunk_q + CW'(1);
                end
            end
            ST_OUTPUT: begin
                if (out_ready_i) begin
                    state_d    = ST_ACCUM;
                    s_d        = '0;
                    c_d        = '0;
                    beat_cnt_d = 8'd0;
                end else begin
                    state_d = ST_OUTPUT;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            s_q         <= '0;
            c_q         <= '0;
            out_data_q  <= '0;
            out_count_q <= 8'd0;
            beat_cnt_q  <= 8'd0;
            chunk_q     <= '0;
            cin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            beat_cnt_q  <= beat_cnt_d;
            chunk_q     <= chunk_d;
            cin_q       <= cin_d;
        end
    end

endmodule
